// File: rtl/mdp_value_iter.sv
// Value-iteration engine for a ROWS x COLS grid-world MDP.
// Runs in-place row-major sweeps, one state per clock, until the largest
// per-sweep utility change is within EPS or the sweep limit is reached.
// Publishes packed utilities, a 2-bit greedy action per state and a done flag.
module mdp_value_iter #(
    parameter int ROWS = 2,
    parameter int COLS = 2,
    parameter int W    = 16,
    parameter int F    = 12,
    parameter int EPS  = 0,
    parameter int IW   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ROWS*COLS*W-1:0]    reward,
    input  logic [ROWS*COLS-1:0]      terminal,
    input  logic [F-1:0]              gamma,
    input  logic [IW-1:0]             max_iter,
    output logic [ROWS*COLS*W-1:0]    cur_util,
    output logic [2*ROWS*COLS-1:0]    policy,
    output logic                      MDP_done,
    output logic                      converged,
    output logic [IW-1:0]             iter_count
);

    localparam int N  = ROWS * COLS;
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW = W + F + 1;
    localparam int XW = W + 2;
    localparam logic signed [XW-1:0] SAT_HI = XW'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [XW-1:0] SAT_LO = XW'(-(64'sd1 <<< (W - 1)));

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_SWEEP = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                start_prev_q;
    logic signed [W-1:0] rew_q  [N];
    logic signed [W-1:0] rew_d  [N];
    logic [N-1:0]        term_q, term_d;
    logic [F-1:0]        gamma_q, gamma_d;
    logic [IW-1:0]       max_iter_q, max_iter_d;
    logic signed [W-1:0] util_q [N];
    logic signed [W-1:0] util_d [N];
    logic [2*N-1:0]      pol_q, pol_d;
    logic                done_q, done_d;
    logic                conv_q, conv_d;
    logic [IW-1:0]       iter_q, iter_d;
    logic [W:0]          delta_q, delta_d;
    logic [SW-1:0]       s_q, s_d;
    logic [RW-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;

    logic                start_rise_s;
    logic [SW-1:0]       idx_up_s, idx_rt_s, idx_dn_s, idx_lt_s;
    logic signed [W-1:0] best_v_s;
    logic [1:0]          best_a_s;
    logic signed [PW-1:0] prod_s, scaled_s;
    logic signed [XW-1:0] sum_s;
    logic signed [W-1:0] new_v_s;
    logic signed [W:0]   diff_s;
    logic [W:0]          absd_s;
    logic [IW-1:0]       iter_inc_s, lim_s;

    assign start_rise_s = start & ~start_prev_q;
    assign iter_inc_s   = iter_q + IW'(1);
    assign lim_s        = (max_iter_q == {IW{1'b0}}) ? IW'(1) : max_iter_q;

    // Bellman backup for the state under the sweep pointer: best neighbour, discount, saturate, delta.
    always_comb begin
        idx_up_s = (row_q == {RW{1'b0}})       ? s_q : s_q - SW'(COLS);
        idx_rt_s = (col_q == CW'(COLS - 1))    ? s_q : s_q + SW'(1);
        idx_dn_s = (row_q == RW'(ROWS - 1))    ? s_q : s_q + SW'(COLS);
        idx_lt_s = (col_q == {CW{1'b0}})       ? s_q : s_q - SW'(1);
        best_v_s = util_q[idx_up_s];
        best_a_s = 2'b00;
        // strict compares keep the lowest action code on ties
        if (util_q[idx_rt_s] > best_v_s) begin
            best_v_s = util_q[idx_rt_s];
            best_a_s = 2'b01;
        end else begin
            best_a_s = best_a_s;
        end
        if (util_q[idx_dn_s] > best_v_s) begin
            best_v_s = util_q[idx_dn_s];
            best_a_s = 2'b10;
        end else begin
            best_a_s = best_a_s;
        end
        if (util_q[idx_lt_s] > best_v_s) begin
            best_v_s = util_q[idx_lt_s];
            best_a_s = 2'b11;
        end else begin
            best_a_s = best_a_s;
        end
        prod_s   = PW'(best_v_s) * PW'($signed({1'b0, gamma_q}));
        scaled_s = prod_s >>> F;
        sum_s    = XW'(rew_q[s_q]) + XW'(scaled_s);
        if (sum_s > SAT_HI) begin
            new_v_s = W'(SAT_HI);
        end else if (sum_s < SAT_LO) begin
            new_v_s = W'(SAT_LO);
        end else begin
            new_v_s = W'(sum_s);
        end
        diff_s = (W+1)'(new_v_s) - (W+1)'(util_q[s_q]);
        absd_s = diff_s[W] ? (W+1)'(-diff_s) : (W+1)'(diff_s);
    end

    // Sequencer and datapath next-state: capture, init, sweep, convergence check, done.
    always_comb begin
        state_d    = state_q;
        rew_d      = rew_q;
        term_d     = term_q;
        gamma_d    = gamma_q;
        max_iter_d = max_iter_q;
        util_d     = util_q;
        pol_d      = pol_q;
        done_d     = done_q;
        conv_d     = conv_q;
        iter_d     = iter_q;
        delta_d    = delta_q;
        s_d        = s_q;
        row_d      = row_q;
        col_d      = col_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_rise_s) begin
                    for (int i = 0; i < N; i++) begin
                        rew_d[i] = reward[i*W +: W];
                    end
                    term_d     = terminal;
                    gamma_d    = gamma;
                    max_iter_d = max_iter;
                    done_d     = 1'b0;
                    state_d    = S_INIT;
                end else begin
                    state_d = state_q;
                end
            end
            S_INIT: begin
                for (int i = 0; i < N; i++) begin
                    util_d[i] = term_q[i] ? rew_q[i] : {W{1'b0}};
                end
                pol_d   = {(2*N){1'b0}};
                done_d  = 1'b0;
                conv_d  = 1'b0;
                iter_d  = {IW{1'b0}};
                delta_d = {(W+1){1'b0}};
                s_d     = {SW{1'b0}};
                row_d   = {RW{1'b0}};
                col_d   = {CW{1'b0}};
                state_d = S_SWEEP;
            end
            S_SWEEP: begin
                if (!term_q[s_q]) begin
                    util_d[s_q]             = new_v_s;
                    pol_d[{s_q, 1'b0} +: 2] = best_a_s;
                    if (absd_s > delta_q) begin
                        delta_d = absd_s;
                    end else begin
                        delta_d = delta_q;
                    end
                end else begin
                    util_d[s_q] = util_q[s_q];
                end
                if (s_q == SW'(N - 1)) begin
                    s_d     = {SW{1'b0}};
                    row_d   = {RW{1'b0}};
                    col_d   = {CW{1'b0}};
                    state_d = S_CHECK;
                end else if (col_q == CW'(COLS - 1)) begin
                    s_d   = s_q + SW'(1);
                    col_d = {CW{1'b0}};
                    row_d = row_q + RW'(1);
                end else begin
                    s_d   = s_q + SW'(1);
                    col_d = col_q + CW'(1);
                end
            end
            S_CHECK: begin
                iter_d = iter_inc_s;
                if (delta_q <= (W+1)'(EPS)) begin
                    conv_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (iter_inc_s == lim_s) begin
                    conv_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    delta_d = {(W+1){1'b0}};
                    state_d = S_SWEEP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                rew_q[i]  <= {W{1'b0}};
                util_q[i] <= {W{1'b0}};
            end
            term_q     <= {N{1'b0}};
            gamma_q    <= {F{1'b0}};
            max_iter_q <= {IW{1'b0}};
            pol_q      <= {(2*N){1'b0}};
            done_q     <= 1'b0;
            conv_q     <= 1'b0;
            iter_q     <= {IW{1'b0}};
            delta_q    <= {(W+1){1'b0}};
            s_q        <= {SW{1'b0}};
            row_q      <= {RW{1'b0}};
            col_q      <= {CW{1'b0}};
        end else begin
            state_q      <= state_d;
            start_prev_q <= start;
            rew_q        <= rew_d;
            util_q       <= util_d;
            term_q       <= term_d;
            gamma_q      <= gamma_d;
            max_iter_q   <= max_iter_d;
            pol_q        <= pol_d;
            done_q       <= done_d;
            conv_q       <= conv_d;
            iter_q       <= iter_d;
            delta_q      <= delta_d;
            s_q          <= s_d;
            row_q        <= row_d;
            col_q        <= col_d;
        end
    end

    // Pack the utility registers onto the output bus.
    always_comb begin
        cur_util = {(N*W){1'b0}};
        for (int i = 0; i < N; i++) begin
            cur_util[i*W +: W] = util_q[i];
        end
    end

    assign policy     = pol_q;
    assign MDP_done   = done_q;
    assign converged  = conv_q;
    assign iter_count = iter_q;

endmodule

// File: doc/mdp_value_iter.md
Name: mdp_value_iter

Overview:
- Parametrised value-iteration engine. Computes the converged utility vector and greedy policy for a ROWS x COLS grid-world MDP.
- Same output contract as the existing fixed-vector MDP stub: packed utilities, 2-bit-per-state policy, and a start/MDP_done handshake. Drop-in successor for downstream policy consumers.
- Processes one state per clock. In-place (Gauss-Seidel) sweeps in row-major order.

Parameters:
- ROWS, 2, grid rows.
- COLS, 2, grid columns. N = ROWS*COLS states.
- W, 16, utility/reward width, signed fixed point Q(W-F).F.
- F, 12, fractional bits. Also the width of gamma (unsigned Q0.F).
- EPS, 0, convergence threshold on |delta|, in LSBs.
- IW, 16, iteration counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  level; a 0->1 edge sampled in IDLE or DONE launches a run.
- reward  in  N*W  per-state reward, signed; state s at [s*W +: W].
- terminal  in  N  terminal-state mask; bit s set means state s is terminal.
- gamma  in  F  discount factor, unsigned Q0.F.
- max_iter  in  IW  sweep limit; 0 is treated as 1.
- cur_util  out  N*W  utilities; state s at [s*W +: W].
- policy  out  2*N  action per state at [2s +: 2]: 00 up, 01 right, 10 down, 11 left.
- MDP_done  out  1  high in DONE.
- converged  out  1  valid with MDP_done; 1 = stopped on EPS, 0 = stopped on max_iter.
- iter_count  out  IW  sweeps executed in the last run.

Behaviour:
- Reset: cur_util, policy, MDP_done, converged, iter_count are all 0; FSM goes to IDLE. Reset mid-run aborts the run with no partial results kept.
- Start capture: reward, terminal, gamma and max_iter are registered on acceptance. Later input changes do not affect the run. Start edges outside IDLE/DONE are ignored.
- FSM states: IDLE -> INIT -> SWEEP -> CHECK -> (SWEEP | DONE). DONE -> INIT on a new start edge.
- INIT (1 cycle):
  - util[s] = reward[s] if terminal[s], else 0.
  - policy = 0, MDP_done = 0, iter_count = 0, max_delta = 0.
- SWEEP (N cycles, index s = 0..N-1, row = s/COLS, col = s%COLS):
  - Neighbours: up = s-COLS, right = s+1, down = s+COLS, left = s-1. A move off the grid maps to s itself.
  - Transitions are deterministic; neighbour values are the current register contents, so updates earlier in the same sweep are visible.
  - Select the maximum neighbour utility (signed compare). Ties go to the lowest action code.
  - new = reward[s] + ((max * gamma) >>> F). The product is signed (W+F+1 bits); the shift is arithmetic, i.e. floor. The sum is saturated to [-2^(W-1), 2^(W-1)-1].
  - Non-terminal states: write util[s] = new and policy[s] = chosen action, and update max_delta with |new - old|.
  - Terminal states: util and policy are left unchanged (policy stays 00).
- CHECK (1 cycle):
  - iter_count increments.
  - If max_delta <= EPS: converged = 1, go to DONE.
  - Else if iter_count == max(max_iter, 1): converged = 0, go to DONE.
  - Else clear max_delta and return to SWEEP at s = 0.
- DONE: MDP_done = 1, and all outputs hold until reset or the next accepted start.
- Latency: for k sweeps, MDP_done rises 1 + k*(N+1) cycles after the accepting edge.
- Outputs cur_util and policy update live during the run. They are valid only while MDP_done = 1.

Test Plan:
- Convergence, defaults, EPS=0. terminal=4'b1000, reward[3]=0x1000, other rewards 0, gamma=0x0E66, max_iter=10, start edge.
  - MDP_done rises after 16 cycles.
  - iter_count=3, converged=1.
  - util = {s3 0x1000, s2 0x0E66, s1 0x0E66, s0 0x0CF5}.
  - policy = 8'h19.
- Iteration cap. Same stimulus with max_iter=1.
  - MDP_done after 6 cycles, converged=0, iter_count=1.
  - util = {0x1000, 0x0E66, 0x0E66, 0x0000}, policy = 8'h18.
- Negative terminal. Same as the first test but reward[3]=0xF000.
  - iter_count=1, converged=1.
  - util s0..s2 = 0, s3 = 0xF000, policy = 0 (states avoid the terminal).
- Saturation. terminal=0, all rewards 0x7F00, gamma=0x0FFF, max_iter=20.
  - Every util = 0x7FFF, iter_count=3, converged=1, no wrap to negative.
- Handshake robustness:
  - A start toggle mid-sweep is ignored and the result is identical to the first test.
  - rst asserted mid-SWEEP clears all outputs to 0 and MDP_done stays 0.
  - A new start from DONE re-runs with updated captured inputs.
